// File: rtl/demux1_4_tdm_pkg.sv
// Shared constants and state encoding for the TDM 1:4 demultiplexer.
// Optional feature macro: DEMUX_PARITY_EN (adds a fifth, even-parity slot).
package demux_pkg;

`ifdef DEMUX_PARITY_EN
  localparam int NUM_SLOTS = 5;
  localparam int SLOT_W    = 3;
`else
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
`endif

  // Bits held in the shadow register before the closing slot arrives.
  localparam int SHADOW_W = NUM_SLOTS - 1;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/demux1_4_tdm_slot_counter.sv
// Wrapping slot index counter for the TDM demultiplexer.
// clr has priority over load1, which has priority over en.
// Optional feature macro: DEMUX_PARITY_EN (widens the counter via the package).
module tdm_slot_counter
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  // Flag the final slot of a frame so the top can close the word.
  always_comb begin
    last_slot = (slot == SLOT_W'(NUM_SLOTS - 1));
  end

  // Slot register: clear, restart at slot 1 after a marker, or advance/wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= last_slot ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/demux1_4_tdm.sv
// Receive-side TDM 1:4 demultiplexer: locks to a frame marker, collects one
// bit per slot and presents a registered parallel word with a valid strobe.
// Optional feature macro: DEMUX_PARITY_EN (5-slot frames, parity_err output).
//
// Input handshake: valid_in qualifies data_in and frame_in; a cycle with
// valid_in low is a stall that consumes no slot and changes no state. There is
// no back-pressure. data_valid is a single-cycle strobe and data_out changes
// only in the cycle data_valid is high. locked mirrors the FSM state.
module demux1_4_tdm
  import demux_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int ERR_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              frame_in,
  input  logic              valid_in,
  output logic [NUM_CH-1:0] data_out,
  output logic              data_valid,
  output logic [SLOT_W-1:0] sel_out,
`ifdef DEMUX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              locked,
  output logic              frame_err
);

  state_t              state, next_state;
  logic [SLOT_W-1:0]   slot;
  logic                last_slot;
  logic [SHADOW_W-1:0] shadow;
  logic                cnt_en, cnt_load1, cnt_clr;
  logic                cap_first, cap_slot, frame_done, err_now;
  logic [NUM_CH-1:0]   word_next;

  tdm_slot_counter u_slot_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .load1     (cnt_load1),
    .clr       (cnt_clr),
    .slot      (slot),
    .last_slot (last_slot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= next_state;
  end

  // Next state and per-cycle control: markers restart a frame, a missing
  // marker drops lock, an early marker flags an error but keeps lock.
  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    cnt_load1  = 1'b0;
    cnt_clr    = 1'b0;
    cap_first  = 1'b0;
    cap_slot   = 1'b0;
    frame_done = 1'b0;
    err_now    = 1'b0;
    case (state)
      ST_HUNT: begin
        if (valid_in && frame_in) begin
          cap_first  = 1'b1;
          cnt_load1  = 1'b1;
          next_state = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (valid_in) begin
          if (frame_in) begin
            cap_first = 1'b1;
            cnt_load1 = 1'b1;
            err_now   = (slot != '0);
          end else if (slot == '0) begin
            err_now    = 1'b1;
            cnt_clr    = 1'b1;
            next_state = ST_HUNT;
          end else begin
            cnt_en     = 1'b1;
            frame_done = last_slot;
            cap_slot   = !last_slot;
          end
        end
      end
      default: next_state = ST_HUNT;
    endcase
  end

  // Assemble the delivered word; without parity the closing bit is slot 3.
  always_comb begin
`ifdef DEMUX_PARITY_EN
    word_next = NUM_CH'(shadow);
`else
    word_next = NUM_CH'({data_in, shadow});
`endif
  end

  // Shadow register collecting the bits of the frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (cap_first) begin
      shadow[0] <= data_in;
    end else if (cap_slot) begin
      for (int i = 1; i < SHADOW_W; i++) begin
        if (slot == SLOT_W'(i)) shadow[i] <= data_in;
      end
    end
  end

  // Registered outputs: word and strobe on frame completion, error indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= frame_done;
      if (frame_done) data_out <= word_next;
      if (ERR_HOLD != 0) frame_err <= frame_err | err_now;
      else               frame_err <= err_now;
    end
  end

`ifdef DEMUX_PARITY_EN
  // Even parity across slots 0..4: any odd total is a mismatch.
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= frame_done && ((^shadow) ^ data_in);
  end
`endif

  // Monitor outputs reflect the counter and FSM directly.
  always_comb begin
    sel_out = slot;
    locked  = (state == ST_LOCKED);
  end

endmodule

// File: tb/tb_demux1_4_tdm.sv
// Self-checking bench for demux1_4_tdm: directed steps followed by random
// traffic, checked cycle by cycle against a frame-level reference model.
// Optional feature macro: DEMUX_PARITY_EN.
module tb_demux1_4_tdm;

`ifdef DEMUX_PARITY_EN
  localparam int N_SLOTS = 5;
  localparam int SW      = 3;
`else
  localparam int N_SLOTS = 4;
  localparam int SW      = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_in = 1'b0;
  logic          frame_in = 1'b0;
  logic          valid_in = 1'b0;
  logic [3:0]    data_out;
  logic          data_valid;
  logic [SW-1:0] sel_out;
  logic          locked;
  logic          frame_err;
`ifdef DEMUX_PARITY_EN
  logic          parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: either hunting, or holding the bits of the current frame.
  bit       m_hunting = 1'b1;
  bit       m_bits[$];
  bit [3:0] exp_dout = 4'b0;
  bit       exp_dv   = 1'b0;
  bit       exp_err  = 1'b0;
  bit       exp_perr = 1'b0;

  demux1_4_tdm #(.NUM_CH(4), .ERR_HOLD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .frame_in   (frame_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sel_out    (sel_out),
`ifdef DEMUX_PARITY_EN
    .parity_err (parity_err),
`endif
    .locked     (locked),
    .frame_err  (frame_err)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hunting = 1'b1;
    m_bits.delete();
    exp_dout = 4'b0;
    exp_dv   = 1'b0;
    exp_err  = 1'b0;
    exp_perr = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit f, input bit v);
    bit p;
    exp_dv   = 1'b0;
    exp_err  = 1'b0;
    exp_perr = 1'b0;
    if (v) begin
      if (m_hunting) begin
        if (f) begin
          m_bits.delete();
          m_bits.push_back(d);
          m_hunting = 1'b0;
        end
      end else if (m_bits.size() == 0) begin
        if (f) m_bits.push_back(d);
        else begin
          exp_err   = 1'b1;
          m_hunting = 1'b1;
        end
      end else if (f) begin
        exp_err = 1'b1;
        m_bits.delete();
        m_bits.push_back(d);
      end else begin
        m_bits.push_back(d);
        if (m_bits.size() == N_SLOTS) begin
          p = 1'b0;
          for (int i = 0; i < N_SLOTS; i++) p ^= m_bits[i];
          for (int i = 0; i < 4; i++) exp_dout[i] = m_bits[i];
          exp_dv   = 1'b1;
          exp_perr = p;
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic check_all();
    check("data_out",   data_out,             exp_dout);
    check("data_valid", {3'b0, data_valid},   {3'b0, exp_dv});
    check("sel_out",    4'(sel_out),          4'(m_bits.size()));
    check("locked",     {3'b0, locked},       {3'b0, !m_hunting});
    check("frame_err",  {3'b0, frame_err},    {3'b0, exp_err});
`ifdef DEMUX_PARITY_EN
    check("parity_err", {3'b0, parity_err},   {3'b0, exp_perr});
`endif
  endtask

  // Driver: apply one cycle of input, advance the model, check after the edge.
  task automatic step(input bit d, input bit f, input bit v);
    data_in  = d;
    frame_in = f;
    valid_in = v;
    @(posedge clk);
    model_step(d, f, v);
    #1;
    check_all();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_reset();
      #1;
      check_all();
    end
    rst = 1'b0;
    valid_in = 1'b0;
  endtask

  // Send a complete frame; under parity a fifth bit is added, optionally wrong.
  task automatic send_frame(input bit [3:0] w, input bit bad_par);
    for (int i = 0; i < 4; i++) step(w[i], i == 0, 1'b1);
`ifdef DEMUX_PARITY_EN
    step((^w) ^ bad_par, 1'b0, 1'b1);
`else
    if (bad_par) step(1'b0, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    int pos;
    bit m;
    do_reset(2);

    // Frames 0101 then 1010 back-to-back.
    send_frame(4'b0101, 1'b0);
    check("f0101_word", data_out, 4'b0101);
    check("f0101_dv", {3'b0, data_valid}, 4'd1);
    send_frame(4'b1010, 1'b0);
    check("f1010_word", data_out, 4'b1010);
    step(1'b0, 1'b0, 1'b0);
    check("dv_one_cycle", {3'b0, data_valid}, 4'd0);

    // Reset mid-frame discards the partial frame.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    do_reset(2);
    check("rst_word", data_out, 4'b0000);

    // Stall between slots 1 and 2.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("stall_sel", 4'(sel_out), 4'd2);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    step(1'b0, 1'b0, 1'b1);
`endif
    check("stall_word", data_out, 4'b0101);

    // Early marker at slot 2, then complete the restarted frame with 1,1,0.
    m = 1'($urandom_range(0, 1));
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(m, 1'b1, 1'b1);
    check("early_err", {3'b0, frame_err}, 4'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
`ifdef DEMUX_PARITY_EN
    step(m, 1'b0, 1'b1);
`endif
    check("early_word", data_out, {1'b0, 1'b1, 1'b1, m});

    // Missing marker drops lock; relock and receive 1010.
    step(1'b1, 1'b0, 1'b1);
    check("miss_err", {3'b0, frame_err}, 4'd1);
    check("miss_locked", {3'b0, locked}, 4'd0);
    check("miss_sel", 4'(sel_out), 4'd0);
    send_frame(4'b1010, 1'b0);
    check("relock_word", data_out, 4'b1010);

`ifdef DEMUX_PARITY_EN
    send_frame(4'b0101, 1'b0);
    check("par_ok", {3'b0, parity_err}, 4'd0);
    send_frame(4'b0101, 1'b1);
    check("par_bad", {3'b0, parity_err}, 4'd1);
    check("par_bad_dv", {3'b0, data_valid}, 4'd1);
`endif

    // Random traffic: mostly well-formed frames with stalls and marker faults.
    pos = 0;
    for (int n = 0; n < 400; n++) begin
      bit v, f, d;
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      f = (pos == 0);
      if ($urandom_range(0, 19) == 0) f = !f;
      step(d, f, v);
      if (v) begin
        if (f) pos = 1;
        else pos = (pos == 0) ? 0 : ((pos + 1) % N_SLOTS);
      end
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
        pos = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux1_4_tdm.md
Name: demux1_4_tdm

Overview:
- Receive-side counterpart to the team's 4:1 mux: a serial time-division stream, with one channel bit per slot, is demultiplexed back into 4 parallel channels.
- Locks to a frame-sync marker and tracks the slot index with a counter.
- Captures each slot into its channel bit and presents a registered 4-bit word with a one-cycle valid strobe per frame.
- Sits between a serial link/mux stage and parallel consumer logic.

Parameters:
- NUM_CH, 4, channels (slots) per frame. The only supported value is 4; the slot counter is 2 bits.
- ERR_HOLD, 0: 0 makes frame_err a one-cycle pulse; 1 makes it sticky until reset.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  1  serial channel bit for the current slot.
- frame_in  input  1  frame marker; high with the slot-0 bit; qualified by valid_in.
- valid_in  input  1  data_in/frame_in meaningful this cycle; low means a stall, with no slot consumed.
- data_out  output  4  last complete frame; data_out[i] = slot i bit.
- data_valid  output  1  one-cycle pulse when data_out updates.
- sel_out  output  2  slot index the next valid bit will fill (debug/monitor).
- locked  output  1  high in LOCKED state.
- frame_err  output  1  framing error indication.

Behaviour:
- Reset (rst=1 at a clock edge):
  - data_out=4'b0000, data_valid=0, sel_out=2'b00, locked=0, frame_err=0.
  - State goes to HUNT and the shadow register is cleared.
  - Reset mid-frame discards the partial frame; no data_valid is generated.
- Two states:
  - HUNT: waiting for sync.
  - LOCKED: tracking slots.
- HUNT:
  - Bits with frame_in=0 are ignored.
  - On valid_in&&frame_in: capture data_in into shadow[0], set slot=1, go to LOCKED.
- LOCKED, on each valid_in=1 cycle:
  - slot 1..3 with frame_in=0: shadow[slot]<=data_in, slot<=slot+1. The counter wraps 3->0.
  - slot 3 captured: on the same edge, data_out<={data_in,shadow[2:0]} and data_valid<=1 for exactly one cycle. Latency is 1 cycle from the slot-3 sample edge to data_out visible.
  - slot 0 with frame_in=1: normal; capture into shadow[0], slot<=1.
  - slot 0 with frame_in=0 (missing marker): frame_err; drop the bit; go to HUNT, slot<=0.
  - slot 1..3 with frame_in=1 (early marker): frame_err; discard the partial frame; treat the bit as a new slot 0 (shadow[0]<=data_in, slot<=1); stay LOCKED.
- valid_in=0: slot, shadow and state hold; data_valid=0; data_out holds.
- data_out changes only together with data_valid=1; otherwise it holds its last value.
- sel_out always equals the internal slot counter; it is 0 in HUNT.
- frame_err behaviour:
  - ERR_HOLD=0: pulse in the cycle after the error edge.
  - ERR_HOLD=1: stays 1 until rst.
- Back-to-back frames with valid_in continuously high give one data_valid every 4 cycles.

Optional Feature:
- Macro DEMUX_PARITY_EN.
- Defined:
  - The frame is 5 slots; slot 4 carries even parity over slots 0..3, and the slot counter is 3 bits.
  - Adds output parity_err (1 bit), pulsed with data_valid when parity mismatches.
  - data_out/data_valid update after slot 4, not slot 3, and the data is still delivered.
- Undefined: 4-slot frames; there is no parity_err port or logic.

Decomposition:
- Package demux_pkg holds:
  - NUM_SLOTS constant: 4, or 5 under DEMUX_PARITY_EN.
  - Slot index width.
  - State encoding: ST_HUNT=1'b0, ST_LOCKED=1'b1.
- One sub-module, tdm_slot_counter:
  - Inputs: enable, load-to-1, clear.
  - Outputs: wrapping slot index and a last_slot flag.
- Capture/strobe logic and the FSM live in the top.

Test Plan:
- Reset: assert rst for 2 cycles mid-stream -> all outputs 0, locked=0, no data_valid.
- Frame 0101: send 1,0,1,0 on consecutive cycles with frame_in on the first bit -> data_out=4'b0101 and data_valid for 1 cycle, 1 cycle after the 4th bit; then frame 1010 back-to-back -> data_out=4'b1010.
- Stall: frame 0101 with valid_in low for 3 cycles between slots 1 and 2 -> same data_out=4'b0101; sel_out holds at 2 during the stall.
- Early marker: frame_in high at slot 2 -> frame_err pulse, no data_valid for that frame; the next 3 bits 1,1,0 complete the frame -> data_out={0,1,1,marker bit}.
- Missing marker: slot 0 arrives with frame_in=0 -> frame_err, locked=0, sel_out=0; relock on the next marker and receive 4'b1010 correctly.
- DEMUX_PARITY_EN: frame 0101 with parity 0 -> parity_err=0; frame 0101 with parity 1 -> parity_err=1 together with data_valid.
